// File: rtl/dram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dram_ctrl_pkg
// Shared types and constants for the 68000 DRAM window controller.
//   state_t            : controller FSM states
//   DEF_* constants    : default timing in 40 MHz CLK cycles
//   ROW_BITS/COL_BITS  : multiplexed address widths of the 4M x 16 array
//   cnt_load()         : converts a cycle count into a down-counter preload
// ---------------------------------------------------------------------------
package dram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_ACK,
    ST_PRE,
    ST_REF_CAS,
    ST_REF_RAS
  } state_t;

  localparam int DEF_REFRESH_CYCLES = 600;
  localparam int DEF_TRCD           = 1;
  localparam int DEF_TCAS           = 2;
  localparam int DEF_TRP            = 2;
  localparam int DEF_TRAS_REF       = 3;

  localparam int ROW_BITS = 11;
  localparam int COL_BITS = 11;

  // Wide enough for the longest per-state hold time.
  localparam int CNT_BITS = 3;

  // A state held N cycles is entered with N-1 and left when the count is 0.
  function automatic logic [CNT_BITS-1:0] cnt_load(input int cycles);
    return CNT_BITS'(cycles - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchronizer for the asynchronous 68000 bus strobes.
// Resets to 1 because every strobe it carries is active-low.
//   CLK : destination clock
//   RST : synchronous reset, active-high
//   d   : asynchronous input
//   q   : synchronized output
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dram_controller.sv
// ---------------------------------------------------------------------------
// dram_controller
// 68000-side responder for the 8 MB DRAM window (one 4M x 16 array).
// Generates multiplexed row/column addresses, RAS/CAS/WE and the active-low
// transfer acknowledge, and runs periodic CAS-before-RAS refresh.
//   CLK        : 40 MHz source clock
//   RST        : synchronous reset, active-high
//   DRAM_CS    : DRAM select from system controller, active-low (async)
//   AS         : CPU address strobe, active-low (async)
//   UDS / LDS  : upper / lower data strobes, active-low (async)
//   RW         : 1 = read, 0 = write
//   ADDR       : CPU address bits 22:1
//   MA         : multiplexed DRAM address
//   RAS_N      : row strobe
//   CASH_N     : column strobe, upper byte
//   CASL_N     : column strobe, lower byte
//   WE_N       : DRAM write enable
//   DTACK_DRAM : transfer acknowledge to the system controller, active-low
// ---------------------------------------------------------------------------
module dram_controller
  import dram_ctrl_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int TRCD           = DEF_TRCD,
  parameter int TCAS           = DEF_TCAS,
  parameter int TRP            = DEF_TRP,
  parameter int TRAS_REF       = DEF_TRAS_REF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                DRAM_CS,
  input  logic                AS,
  input  logic                UDS,
  input  logic                LDS,
  input  logic                RW,
  input  logic [22:1]         ADDR,
  output logic [ROW_BITS-1:0] MA,
  output logic                RAS_N,
  output logic                CASH_N,
  output logic                CASL_N,
  output logic                WE_N,
  output logic                DTACK_DRAM
);

  localparam int                REF_W      = $clog2(REFRESH_CYCLES);
  localparam logic [REF_W-1:0]  REF_RELOAD = REF_W'(REFRESH_CYCLES - 1);

  state_t              state;
  logic [CNT_BITS-1:0] cnt;
  logic [COL_BITS-1:0] col_lat;
  logic                rw_lat;
  logic                ack_n;
  logic [REF_W-1:0]    ref_cnt;
  logic                ref_pending;

  logic as_s, cs_s, uds_s, lds_s;
  logic req, idle_decide, in_access, enter_pre;

  sync_2ff u_sync_as  (.CLK(CLK), .RST(RST), .d(AS),      .q(as_s));
  sync_2ff u_sync_cs  (.CLK(CLK), .RST(RST), .d(DRAM_CS), .q(cs_s));
  sync_2ff u_sync_uds (.CLK(CLK), .RST(RST), .d(UDS),     .q(uds_s));
  sync_2ff u_sync_lds (.CLK(CLK), .RST(RST), .d(LDS),     .q(lds_s));

  // The idle decision is also taken on the last precharge cycle, so an
  // access queued behind a refresh starts right after precharge completes.
  always_comb begin
    req         = ~as_s & ~cs_s;
    idle_decide = (state == ST_IDLE) || ((state == ST_PRE) && (cnt == '0));
    in_access   = (state == ST_ROW) || (state == ST_COL) || (state == ST_ACK);
    enter_pre   = (in_access && as_s) ||
                  ((state == ST_REF_RAS) && (cnt == '0));
  end

  // Free-running refresh timer. A new expiry wins over the clear taken when
  // the refresh enters its RAS phase, so no request is ever dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ref_cnt     <= REF_RELOAD;
      ref_pending <= 1'b0;
    end else if (ref_cnt == '0) begin
      ref_cnt     <= REF_RELOAD;
      ref_pending <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt - 1'b1;
      if (state == ST_REF_CAS) begin
        ref_pending <= 1'b0;
      end
    end
  end

  // Main FSM with registered strobes. Precharge entry (normal end, abort or
  // end of refresh) is handled in one place so every exit releases all
  // strobes together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      col_lat <= '0;
      rw_lat  <= 1'b1;
      ack_n   <= 1'b1;
      MA      <= '0;
      RAS_N   <= 1'b1;
      CASH_N  <= 1'b1;
      CASL_N  <= 1'b1;
      WE_N    <= 1'b1;
    end else if (idle_decide) begin
      if (ref_pending) begin
        state  <= ST_REF_CAS;
        CASH_N <= 1'b0;
        CASL_N <= 1'b0;
      end else if (req) begin
        state   <= ST_ROW;
        cnt     <= cnt_load(TRCD);
        MA      <= ADDR[22:12];
        col_lat <= ADDR[11:1];
        rw_lat  <= RW;
        RAS_N   <= 1'b0;
        WE_N    <= RW;
      end else begin
        state <= ST_IDLE;
      end
    end else if (enter_pre) begin
      state  <= ST_PRE;
      cnt    <= cnt_load(TRP);
      RAS_N  <= 1'b1;
      CASH_N <= 1'b1;
      CASL_N <= 1'b1;
      WE_N   <= 1'b1;
      ack_n  <= 1'b1;
    end else begin
      case (state)
        ST_ROW: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rw_lat || !uds_s || !lds_s) begin
            state  <= ST_COL;
            cnt    <= cnt_load(TCAS);
            MA     <= col_lat;
            CASH_N <= uds_s;
            CASL_N <= lds_s;
          end
        end
        ST_COL: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_ACK;
            ack_n <= 1'b0;
          end
        end
        ST_REF_CAS: begin
          state <= ST_REF_RAS;
          cnt   <= cnt_load(TRAS_REF);
          RAS_N <= 1'b0;
        end
        ST_REF_RAS, ST_PRE: begin
          cnt <= cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Raw AS lets the acknowledge drop the moment the CPU ends its cycle.
  assign DTACK_DRAM = ack_n | AS;

endmodule

// File: tb/tb_dram_controller.sv
// ---------------------------------------------------------------------------
// tb_dram_controller
// Self-checking bench for dram_controller: a table of single accesses plus
// hand-written sequences for reset, delayed data strobe, refresh, refresh
// collision and abort.
// ---------------------------------------------------------------------------
module tb_dram_controller;

  logic        CLK     = 1'b0;
  logic        RST     = 1'b1;
  logic        DRAM_CS = 1'b1;
  logic        AS      = 1'b1;
  logic        UDS     = 1'b1;
  logic        LDS     = 1'b1;
  logic        RW      = 1'b1;
  logic [22:1] ADDR    = '0;
  logic [10:0] MA;
  logic        RAS_N, CASH_N, CASL_N, WE_N, DTACK_DRAM;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    string       name;
    logic [23:0] addrFull;
    logic        rw;
    logic        uds;
    logic        lds;
    logic [10:0] expRow;
    logic [10:0] expCol;
    logic        expCashN;
    logic        expCaslN;
    logic        expWeN;
  } vec_t;

  vec_t vecs[4];

  dram_controller dut (
    .CLK       (CLK),
    .RST       (RST),
    .DRAM_CS   (DRAM_CS),
    .AS        (AS),
    .UDS       (UDS),
    .LDS       (LDS),
    .RW        (RW),
    .ADDR      (ADDR),
    .MA        (MA),
    .RAS_N     (RAS_N),
    .CASH_N    (CASH_N),
    .CASL_N    (CASL_N),
    .WE_N      (WE_N),
    .DTACK_DRAM(DTACK_DRAM)
  );

  // 10-unit clock period; stimulus and sampling happen 1 unit after each edge.
  always #5 CLK = ~CLK;

  // Guard against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b1; DRAM_CS = 1'b1; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic startAccess(input logic [23:0] addrFull, input logic rw,
                             input logic uds, input logic lds);
    ADDR = addrFull[22:1]; RW = rw; UDS = uds; LDS = lds;
    DRAM_CS = 1'b0; AS = 1'b0;
  endtask

  task automatic waitRasHigh(input string name);
    int n = 0;
    while (RAS_N !== 1'b1 && n < 5) begin
      tick();
      n++;
    end
    checkOutput({name, "_ras_release"}, {31'd0, RAS_N}, 1);
    checkOutput({name, "_cas_we_release"}, {29'd0, CASH_N, CASL_N, WE_N}, 3'b111);
  endtask

  // Ends the CPU cycle: acknowledge must drop within the same cycle.
  task automatic endAccess(input string name);
    AS = 1'b1; DRAM_CS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    #1;
    checkOutput({name, "_dtack_release"}, {31'd0, DTACK_DRAM}, 1);
    waitRasHigh(name);
    repeat (3) tick();
  endtask

  // One nominal access: RAS at edge 3, CAS at edge 4, DTACK at edge 6.
  task automatic applyStimulus(input vec_t v, input bit withReset);
    if (withReset) doReset();
    startAccess(v.addrFull, v.rw, v.uds, v.lds);
    tick(); tick();
    checkOutput({v.name, "_ras_e2"}, {31'd0, RAS_N}, 1);
    tick();
    checkOutput({v.name, "_ras_e3"}, {31'd0, RAS_N}, 0);
    checkOutput({v.name, "_row"}, {21'd0, MA}, {21'd0, v.expRow});
    checkOutput({v.name, "_we"}, {31'd0, WE_N}, {31'd0, v.expWeN});
    checkOutput({v.name, "_cas_e3"}, {30'd0, CASH_N, CASL_N}, 2'b11);
    tick();
    checkOutput({v.name, "_col"}, {21'd0, MA}, {21'd0, v.expCol});
    checkOutput({v.name, "_cas_e4"}, {30'd0, CASH_N, CASL_N}, {30'd0, v.expCashN, v.expCaslN});
    tick();
    checkOutput({v.name, "_dtack_e5"}, {31'd0, DTACK_DRAM}, 1);
    tick();
    checkOutput({v.name, "_dtack_e6"}, {31'd0, DTACK_DRAM}, 0);
    endAccess(v.name);
  endtask

  initial begin
    int early;
    int dtackSeen;
    int nRef;
    int refStart[3];
    int rasFall[3];
    int rasLen[3];
    int nFall;
    int nLen;
    logic prevCas, prevRas;

    vecs[0] = '{"rd_word_100000", 24'h100000, 1'b1, 1'b0, 1'b0, 11'h100, 11'h000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"rd_upper_8ffffe", 24'h8FFFFE, 1'b1, 1'b0, 1'b1, 11'h0FF, 11'h7FF, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"wr_word_2aaaaa", 24'h2AAAAA, 1'b0, 1'b0, 1'b0, 11'h2AA, 11'h555, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"wr_lower_555554", 24'h555554, 1'b0, 1'b1, 1'b0, 11'h555, 11'h2AA, 1'b1, 1'b0, 1'b0};

    $display("[TB] start");

    // Reset state
    doReset();
    checkOutput("reset_strobes", {27'd0, RAS_N, CASH_N, CASL_N, WE_N, DTACK_DRAM}, 5'b11111);
    checkOutput("reset_ma", {21'd0, MA}, 0);

    // Table of single accesses
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b1);

    // Reset asserted while the access sits in ACK
    doReset();
    startAccess(24'h2AAAAA, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    checkOutput("rst_ack_dtack_before", {31'd0, DTACK_DRAM}, 0);
    RST = 1'b1;
    tick();
    checkOutput("rst_ack_strobes", {27'd0, RAS_N, CASH_N, CASL_N, WE_N, DTACK_DRAM}, 5'b11111);
    checkOutput("rst_ack_ma", {21'd0, MA}, 0);
    RST = 1'b0; AS = 1'b1; DRAM_CS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    early = 0;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (RAS_N !== 1'b1 || CASH_N !== 1'b1 || CASL_N !== 1'b1) early = 1;
    end
    checkOutput("rst_no_early_refresh", early, 0);
    tick();
    checkOutput("rst_refresh_at_601", {29'd0, CASH_N, CASL_N, RAS_N}, 3'b001);
    repeat (10) tick();

    // Byte write, LDS only, data strobe two cycles after AS
    doReset();
    startAccess(24'h123456, 1'b0, 1'b1, 1'b1);
    tick(); tick();
    LDS = 1'b0;
    tick();
    checkOutput("bw_ras_e3", {31'd0, RAS_N}, 0);
    checkOutput("bw_we_e3", {31'd0, WE_N}, 0);
    checkOutput("bw_row", {21'd0, MA}, 11'h123);
    tick();
    checkOutput("bw_cas_wait_e4", {30'd0, CASH_N, CASL_N}, 2'b11);
    tick();
    checkOutput("bw_cas_e5", {30'd0, CASH_N, CASL_N}, 2'b10);
    checkOutput("bw_col", {21'd0, MA}, 11'h22B);
    tick();
    checkOutput("bw_dtack_e6", {31'd0, DTACK_DRAM}, 1);
    tick();
    checkOutput("bw_dtack_e7", {31'd0, DTACK_DRAM}, 0);
    endAccess("bw");

    // Abort: AS released during ROW, seen by the FSM in COL
    doReset();
    startAccess(24'h100000, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    AS = 1'b1; DRAM_CS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    dtackSeen = 0;
    tick();
    checkOutput("abort_in_col", {30'd0, CASH_N, CASL_N}, 2'b00);
    if (DTACK_DRAM !== 1'b1) dtackSeen = 1;
    tick();
    if (DTACK_DRAM !== 1'b1) dtackSeen = 1;
    tick();
    checkOutput("abort_ras_release", {31'd0, RAS_N}, 1);
    checkOutput("abort_cas_release", {30'd0, CASH_N, CASL_N}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      if (DTACK_DRAM !== 1'b1) dtackSeen = 1;
      tick();
    end
    checkOutput("abort_no_dtack", dtackSeen, 0);
    applyStimulus(vecs[0], 1'b0);

    // Collision: synced request appears the cycle refresh goes pending
    doReset();
    repeat (598) tick();
    startAccess(24'h100000, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    checkOutput("coll_ref_cas_first", {29'd0, CASH_N, CASL_N, RAS_N}, 3'b001);
    tick();
    checkOutput("coll_ref_ras", {31'd0, RAS_N}, 0);
    repeat (3) tick();
    checkOutput("coll_pre", {31'd0, RAS_N}, 1);
    tick();
    checkOutput("coll_pre2", {31'd0, RAS_N}, 1);
    tick();
    checkOutput("coll_row_ras", {31'd0, RAS_N}, 0);
    checkOutput("coll_row_ma", {21'd0, MA}, 11'h100);
    tick(); tick();
    checkOutput("coll_dtack_early", {31'd0, DTACK_DRAM}, 1);
    tick();
    checkOutput("coll_dtack", {31'd0, DTACK_DRAM}, 0);
    endAccess("coll");

    // Idle refresh over 1800+ cycles
    doReset();
    nRef = 0; nFall = 0; nLen = 0;
    for (int i = 0; i < 3; i++) begin
      refStart[i] = -1; rasFall[i] = -1; rasLen[i] = -1;
    end
    prevCas = 1'b1; prevRas = 1'b1;
    for (int k = 1; k <= 1810; k++) begin
      tick();
      if (CASL_N === 1'b0 && CASH_N === 1'b0 && RAS_N === 1'b1 && prevCas === 1'b1) begin
        if (nRef < 3) refStart[nRef] = k;
        nRef++;
      end
      if (RAS_N === 1'b0 && prevRas === 1'b1) begin
        if (nFall < 3) rasFall[nFall] = k;
        nFall++;
      end
      if (RAS_N === 1'b1 && prevRas === 1'b0) begin
        if (nLen < 3 && nFall > 0 && nFall <= 3) rasLen[nLen] = k - rasFall[nFall-1];
        nLen++;
      end
      prevCas = CASL_N;
      prevRas = RAS_N;
    end
    checkOutput("idle_ref_count", nRef, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("idle_ref%0d_start", i), refStart[i], 601 + 600 * i);
      checkOutput($sformatf("idle_ref%0d_ras_fall", i), rasFall[i], 602 + 600 * i);
      checkOutput($sformatf("idle_ref%0d_ras_len", i), rasLen[i], 3);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dram_controller.md
Name: dram_controller

Overview:
- 68000-side responder for the DRAM window at 0x100000–0x8FFFFF (8 MB, one 4M x 16 array).
- Accepts the active-low DRAM select from the system controller together with the CPU bus strobes, and generates multiplexed row/column addresses, RAS/CAS/WE and the active-low DTACK_DRAM returned to the system controller.
- Performs periodic CAS-before-RAS refresh.
- Runs on the 40 MHz source clock (25 ns/cycle); all bus inputs are asynchronous to it.

Parameters:
- REFRESH_CYCLES, 600, CLK cycles between refresh requests (15 µs).
- TRCD, 1, cycles RAS low before CAS (row hold).
- TCAS, 2, cycles CAS low before DTACK asserts.
- TRP, 2, RAS/CAS precharge cycles after any access or refresh.
- TRAS_REF, 3, cycles RAS low during refresh.

Ports:
- CLK  in  1  40 MHz source clock.
- RST  in  1  synchronous reset, active-high.
- DRAM_CS  in  1  DRAM select from system controller, active-low.
- AS  in  1  CPU address strobe, active-low.
- UDS  in  1  upper data strobe, active-low.
- LDS  in  1  lower data strobe, active-low.
- RW  in  1  1 = read, 0 = write.
- ADDR  in  22  CPU ADDR[22:1].
- MA  out  11  multiplexed DRAM address.
- RAS_N  out  1  row strobe.
- CASH_N  out  1  column strobe, upper byte.
- CASL_N  out  1  column strobe, lower byte.
- WE_N  out  1  DRAM write enable.
- DTACK_DRAM  out  1  transfer acknowledge, active-low.

Behaviour:
- Reset: one clock with RST high, from any state including mid-access or mid-refresh, forces:
  - outputs RAS_N = CASH_N = CASL_N = WE_N = DTACK_DRAM = 1, MA = 0;
  - state IDLE;
  - refresh counter reloaded to REFRESH_CYCLES-1; refresh pending cleared;
  - synchronizers cleared to 1 (inactive).
- Synchronization: AS, DRAM_CS, UDS and LDS each pass through a 2-flop synchronizer. A request is synced AS low AND synced DRAM_CS low.
- Address mapping: row = ADDR[22:12], col = ADDR[11:1]. ADDR and RW are latched on the IDLE→ROW transition.
- States: IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS.
- IDLE:
  - Refresh pending → REF_CAS (refresh has priority on a simultaneous request).
  - Otherwise request → ROW.
- ROW:
  - RAS_N = 0, MA = row; WE_N = latched RW.
  - Held TRCD cycles.
  - For writes, additionally hold until synced UDS or LDS is low.
  - Then → COL.
- COL:
  - MA = col.
  - CASH_N = synced UDS and CASL_N = synced LDS, sampled on entry and held.
  - Held TCAS cycles, then → ACK.
- ACK:
  - DTACK_DRAM = 0; RAS/CAS/WE held.
  - Leave when synced AS is high → PRE.
  - DTACK_DRAM is the registered ACK flag OR'd with raw AS, so it negates combinationally as soon as AS rises.
- Abort: synced AS high while in ROW or COL → PRE immediately, with no DTACK.
- PRE: RAS_N = CASx_N = WE_N = 1 for TRP cycles, then → IDLE.
- REF_CAS: CASH_N = CASL_N = 0 for 1 cycle, then → REF_RAS.
- REF_RAS:
  - RAS_N = 0 with CAS still low, for TRAS_REF cycles.
  - Refresh pending is cleared on entry.
  - Then → PRE.
- Refresh timer:
  - Down-counter, free-running in all states.
  - At 0 it sets pending and reloads REFRESH_CYCLES-1.
  - An expiry while already pending is absorbed (flag stays 1, no count kept).
- Nominal read latency from AS first sampled low:
  - RAS_N falls at edge 3.
  - CAS falls at edge 3+TRCD.
  - DTACK_DRAM falls at edge 3+TRCD+TCAS (= 6 with defaults).
- WE_N is never low outside ROW/COL/ACK of a write. CAS is never low while RAS is high, except in REF_CAS.

Decomposition:
- Package dram_ctrl_pkg: state enum; default timing constants; ROW_BITS = 11, COL_BITS = 11.
- Sub-module sync_2ff: one-bit 2-flop synchronizer with reset value 1, instantiated four times.
- Refresh timer and FSM stay in dram_controller.

Test Plan:
- Reset: hold RST 1 cycle during an ACK → next cycle all strobes 1, DTACK_DRAM 1, MA 0; no refresh for 600 cycles afterward.
- Word read at ADDR_FULL 0x100000:
  - MA = 0x100 with RAS_N low at edge 3.
  - MA = 0x000 with both CAS low at edge 4.
  - DTACK_DRAM low at edge 6.
  - AS high → DTACK_DRAM high same cycle, RAS_N high next edge.
- Byte write 0x123456, LDS only, DS 2 cycles after AS:
  - WE_N low; row 0x123.
  - CAS waits for DS; col 0x22B.
  - CASL_N low, CASH_N stays 1.
- Idle refresh: no traffic for 1800 cycles → exactly 3 CAS-before-RAS sequences, 600 cycles apart, CAS low 1 cycle before RAS, RAS low 3 cycles.
- Collision: request arrives the cycle refresh goes pending → refresh runs first, then PRE, then the access; DTACK delayed by 1+3+2 cycles.
- Abort: AS high during COL → PRE with no DTACK pulse; the next access completes normally.
